// File: rtl/btn_conditioner.sv
// Push-button front end: 2-flop synchroniser, per-button debounce, and a direction
// arbiter that keeps btn_out[4:1] either all-zero or exactly one-hot.
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn_raw,
    output logic [4:0] btn_out,
    output logic [4:0] press_pulse,
    output logic       multi_dir
);

    typedef enum logic {
        IDLE,
        HOLD
    } arb_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [4:0]       sync1;
    logic [4:0]       sync2;
    logic [4:0]       stable;
    logic [4:0]       stable_d;
    logic [CNT_W-1:0] cnt [5];

    arb_state_t state;
    arb_state_t state_nxt;
    logic [3:0] dir_low;
    logic [3:0] dir_nxt;
    logic       multi_nxt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Each counter only runs while its input disagrees with the accepted level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable <= '0;
            for (int i = 0; i < 5; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Isolate the lowest set direction bit.
    assign dir_low = stable[4:1] & (~stable[4:1] + 4'd1);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        dir_nxt   = btn_out[4:1];
        unique case (state)
            IDLE: begin
                dir_nxt = '0;
                if (stable[4:1] != 4'b0) begin
                    dir_nxt   = dir_low;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                // The registered grant doubles as the held index.
                if ((stable[4:1] & btn_out[4:1]) == 4'b0) begin
                    dir_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    assign multi_nxt = ($countones(stable[4:1]) >= 2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            stable_d    <= '0;
            btn_out     <= '0;
            press_pulse <= '0;
            multi_dir   <= 1'b0;
        end else begin
            state       <= state_nxt;
            stable_d    <= stable;
            btn_out     <= {dir_nxt, stable[0]};
            press_pulse <= stable & ~stable_d;
            multi_dir   <= multi_nxt;
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4; edge counts are
// taken from the rising edge that first samples a changed input.
module tb_btn_conditioner;

    logic       clk;
    logic       rst;
    logic [4:0] btn_raw;
    logic [4:0] btn_out;
    logic [4:0] press_pulse;
    logic       multi_dir;

    int n_checks = 0;
    int n_fail   = 0;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_out    (btn_out),
        .press_pulse(press_pulse),
        .multi_dir  (multi_dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Direction field must never be multi-hot.
    always @(negedge clk) begin
        if (rst) check("dir_onehot0", 32'($onehot0(btn_out[4:1])), 32'd1);
    end

    initial begin
        rst     = 1'b0;
        btn_raw = '0;
        step(2);
        check("rst_out", 32'(btn_out), 32'h00);
        check("rst_pulse", 32'(press_pulse), 32'h00);
        check("rst_multi", 32'(multi_dir), 32'd0);
        rst = 1'b1;
        step(3);

        // 1: single press and release of up
        btn_raw = 5'b00010;
        step(6);
        check("t1_edge6_out", 32'(btn_out), 32'h00);
        step(1);
        check("t1_edge7_out", 32'(btn_out), 32'h02);
        check("t1_edge7_pulse", 32'(press_pulse), 32'h02);
        step(1);
        check("t1_edge8_pulse", 32'(press_pulse), 32'h00);
        check("t1_edge8_out", 32'(btn_out), 32'h02);
        step(4);
        btn_raw = 5'b00000;
        step(6);
        check("t1_rel_edge6_out", 32'(btn_out), 32'h02);
        step(1);
        check("t1_rel_edge7_out", 32'(btn_out), 32'h00);
        check("t1_rel_edge7_pulse", 32'(press_pulse), 32'h00);
        step(5);

        // 2: 3-cycle glitch rejected, 4-cycle pulse accepted
        btn_raw = 5'b01000;
        step(3);
        btn_raw = 5'b00000;
        for (int k = 0; k < 12; k++) begin
            step(1);
            check("t2_glitch_out", 32'(btn_out), 32'h00);
            check("t2_glitch_pulse", 32'(press_pulse), 32'h00);
        end
        btn_raw = 5'b01000;
        step(4);
        btn_raw = 5'b00000;
        step(2);
        check("t2_edge6_out", 32'(btn_out), 32'h00);
        step(1);
        check("t2_edge7_out", 32'(btn_out), 32'h08);
        check("t2_edge7_pulse", 32'(press_pulse), 32'h08);
        step(3);
        check("t2_edge10_out", 32'(btn_out), 32'h08);
        step(1);
        check("t2_edge11_out", 32'(btn_out), 32'h00);
        step(5);

        // 3: right held, then up added; release right hands over to up
        btn_raw = 5'b01000;
        step(20);
        check("t3_right_out", 32'(btn_out), 32'h08);
        btn_raw = 5'b01010;
        step(6);
        check("t3_edge6_multi", 32'(multi_dir), 32'd0);
        step(1);
        check("t3_hold_out", 32'(btn_out), 32'h08);
        check("t3_multi", 32'(multi_dir), 32'd1);
        check("t3_up_pulse", 32'(press_pulse), 32'h02);
        step(5);
        btn_raw = 5'b00010;
        step(6);
        check("t3_rel_edge6_out", 32'(btn_out), 32'h08);
        step(1);
        check("t3_gap_out", 32'(btn_out), 32'h00);
        check("t3_gap_multi", 32'(multi_dir), 32'd0);
        step(1);
        check("t3_up_out", 32'(btn_out), 32'h02);
        check("t3_up_nopulse", 32'(press_pulse), 32'h00);
        btn_raw = 5'b00000;
        step(10);

        // 4: down and left accepted on the same edge
        btn_raw = 5'b10100;
        step(7);
        check("t4_out", 32'(btn_out), 32'h04);
        check("t4_pulse", 32'(press_pulse), 32'h14);
        check("t4_multi", 32'(multi_dir), 32'd1);
        step(1);
        check("t4_pulse_off", 32'(press_pulse), 32'h00);
        check("t4_out_hold", 32'(btn_out), 32'h04);
        btn_raw = 5'b00000;
        step(10);
        check("t4_released", 32'(btn_out), 32'h00);

        // 5: centre alongside a direction
        btn_raw = 5'b00101;
        step(7);
        check("t5_out", 32'(btn_out), 32'h05);
        check("t5_pulse", 32'(press_pulse), 32'h05);
        btn_raw = 5'b00000;
        step(10);

        // 6: reset in the middle of a count restarts the debounce
        btn_raw = 5'b00010;
        step(4);
        rst = 1'b0;
        #1;
        check("t6_rst_out", 32'(btn_out), 32'h00);
        step(2);
        rst = 1'b1;
        step(1);
        check("t6_post_edge1_out", 32'(btn_out), 32'h00);
        step(5);
        check("t6_post_edge6_out", 32'(btn_out), 32'h00);
        step(1);
        check("t6_post_edge7_out", 32'(btn_out), 32'h02);
        check("t6_post_edge7_pulse", 32'(press_pulse), 32'h02);
        step(1);

        // Asynchronous clear of live outputs, observed before any clock edge
        rst = 1'b0;
        #1;
        check("async_out", 32'(btn_out), 32'h00);
        check("async_pulse", 32'(press_pulse), 32'h00);
        check("async_multi", 32'(multi_dir), 32'd0);
        btn_raw = 5'b00000;
        step(1);
        rst = 1'b1;
        step(3);
        check("final_out", 32'(btn_out), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
Front-end producer for the game's `btn[4:0]` input. It synchronises and debounces the five raw push-buttons. It guarantees that the direction field `btn[4:1]` is either all-zero or exactly one-hot (0001 up, 0010 left, 0100 right, 1000 down), which is what the movement logic decodes. It sits between the board pins and the game top, on the 100 MHz system clock.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronised input must differ from its stable value before the change is accepted (10 ms at 100 MHz); legal range 2..2^CNT_W-1.
CNT_W, 20, width of each per-button debounce counter.

Ports:
clk  input  1  system clock, 100 MHz.
rst  input  1  asynchronous reset, active-low (0 = reset).
btn_raw  input  5  raw pin levels: [0] centre/restart, [1] up, [2] left, [3] right, [4] down.
btn_out  output  5  conditioned buttons: [0] debounced centre, [4:1] one-hot-or-zero direction.
press_pulse  output  5  one-cycle pulse per button on its debounced rising edge.
multi_dir  output  1  high while more than one debounced direction is pressed.

Behaviour:
- Reset (`rst`=0, async): sync flops, stable[4:0], all counters, `btn_out`, `press_pulse`, `multi_dir` = 0; arbiter state IDLE. Release is sampled normally on the next edge.
- Synchroniser: 2-flop chain per bit: `sync1` <= `btn_raw`, `sync2` <= `sync1`.
- Debounce, per bit i, independent:
  - If `sync2[i]` == stable[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: stable[i] <= `sync2[i]`, cnt[i] <= 0.
  - Else cnt[i] <= cnt[i]+1.
  - Any return to match before acceptance clears the counter. A raw pulse lasting exactly DEBOUNCE_CYCLES cycles is accepted; DEBOUNCE_CYCLES-1 cycles is rejected.
  - Same rule for press and release.
- Latency: a raw edge sampled at rising edge 1 updates stable at edge DEBOUNCE_CYCLES+2. All outputs are registered and update at edge DEBOUNCE_CYCLES+3.
- Centre: `btn_out[0]` <= stable[0]. No arbitration.
- Direction arbiter FSM, states IDLE and HOLD, granted index g in 1..4:
  - IDLE: if stable[4:1] != 0, grant the lowest set index. `btn_out[4:1]` <= one-hot(g), go HOLD. Otherwise `btn_out[4:1]` <= 0.
  - HOLD: while stable[g] = 1, keep the output unchanged, even if other directions are pressed or released.
  - HOLD, when stable[g] = 0: `btn_out[4:1]` <= 0 and go IDLE. This gives at least one zero cycle between grants. If other directions are still held, the lowest of them is granted on the following edge.
  - Simultaneous acceptance of several directions in IDLE: the lowest index wins.
- `press_pulse[i]` <= stable[i] & ~stable_d[i], where stable_d is stable delayed one cycle.
  - The pulse is aligned with the `btn_out` update edge and is generated for all five bits regardless of arbitration.
  - A re-press gives a new pulse only after a debounced release.
- `multi_dir` <= (popcount(stable[4:1]) >= 2), registered.
- Invariant: `btn_out[4:1]` is never multi-hot on any cycle.
- Counters never wrap: the maximum value is DEBOUNCE_CYCLES-1.

Test Plan:
1. DEBOUNCE_CYCLES=4, CNT_W=3. Raise `btn_raw[1]` after reset and hold it -> `btn_out` = 5'b00010 and `press_pulse[1]`=1 for exactly one cycle, both at edge 7 after the change. Release -> `btn_out` = 0 at edge 7 after the release, with no pulse.
2. Glitch: `btn_raw[3]` high for 3 cycles -> `btn_out` and `press_pulse` stay 0. High for 4 cycles -> `btn_out[3]` asserts at edge 7 and deasserts at edge 11 from the rise.
3. Hold `btn_raw[3]` (right), then 20 cycles later also `btn_raw[1]` (up) -> `btn_out[4:1]` stays 0100 and `multi_dir` becomes 1. Release right -> 0000 for one cycle, then 0001.
4. Press `btn_raw[4]` and `btn_raw[2]` on the same cycle -> `btn_out[4:1]` = 0010 (left), `press_pulse` = 5'b10100, `multi_dir`=1.
5. Centre with direction held: `btn_raw[0]` and `btn_raw[2]` held -> `btn_out` = 5'b00101.
6. Reset mid-count: `btn_raw[1]` held, `rst`=0 at cycle 4 for 2 cycles, then released -> outputs are 0 immediately (async), not on the next edge. The counter restarts and `btn_out[1]` asserts 7 edges after `rst` returns high.
